re_write_ctrl: RTL

RE_WRITE_CTRL -- requirements
Module: re_write_ctrl

---
 rtl/re_write_ctrl_pkg.sv | 22 ++
 rtl/re_write_ctrl_if.sv | 35 +++
 rtl/re_write_ctrl_sc_counter.sv | 60 ++++++
 rtl/re_write_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/re_write_ctrl_pkg.sv
// Shared definitions for the resource-element write controller:
// FSM state encoding, ping-pong memory geometry and counter widths.
package re_write_ctrl_pkg;

    // Ping-pong buffer geometry seen by the writer.
    localparam int unsigned PP_SHIFT  = 423;
    localparam int unsigned MEM_DEPTH = 2048;
    localparam int unsigned ADDR_W    = 11;

    // Symbol counter width (up to 15 symbols per slot) and highest usable subcarrier.
    localparam int unsigned SYM_W     = 4;
    localparam int unsigned MAX_SC    = 1625;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        SYM_END  = 3'd2,
        GAP      = 3'd3,
        SLOT_END = 3'd4
    } re_state_e;

endpackage

// File: rtl/re_write_ctrl_if.sv
// Sample/DMRS handshakes and memory write port of the RE write controller.
// master: upstream source / testbench side; slave: controller side.
interface re_write_ctrl_if #(
    parameter int unsigned FFT_Len = 18
);
    import re_write_ctrl_pkg::*;

    logic                      start;
    logic signed [FFT_Len-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [FFT_Len-1:0] dmrs_data;
    logic                      dmrs_valid;
    logic                      dmrs_ready;
    logic signed [FFT_Len-1:0] wr_data;
    logic                      write_enable;
    logic [ADDR_W-1:0]         write_addr;
    logic                      Sym_Done;
    logic                      RE_Done;
    logic                      busy;
    logic [SYM_W-1:0]          sym_idx;

    modport master (
        output start, in_data, in_valid, dmrs_data, dmrs_valid,
        input  in_ready, dmrs_ready, wr_data, write_enable, write_addr,
               Sym_Done, RE_Done, busy, sym_idx
    );

    modport slave (
        input  start, in_data, in_valid, dmrs_data, dmrs_valid,
        output in_ready, dmrs_ready, wr_data, write_enable, write_addr,
               Sym_Done, RE_Done, busy, sym_idx
    );

endinterface

// File: rtl/re_write_ctrl_sc_counter.sv
// Subcarrier and symbol counters for the RE write controller, with
// terminal-count flags. The subcarrier count wraps to zero only on the
// last subcarrier of a symbol, so it never wraps mid-symbol.
module re_sc_counter
    import re_write_ctrl_pkg::*;
#(
    parameter int unsigned N_SC    = 300,
    parameter int unsigned NUM_SYM = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              slot_clr_i,
    input  logic              sc_inc_i,
    input  logic              sym_inc_i,
    output logic [ADDR_W-1:0] sc_cnt_o,
    output logic [SYM_W-1:0]  sym_cnt_o,
    output logic              sc_last_o,
    output logic              sym_last_o
);

    localparam logic [ADDR_W-1:0] SC_LAST  = ADDR_W'(N_SC - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST = SYM_W'(NUM_SYM - 1);

    logic [ADDR_W-1:0] sc_cnt_q, sc_cnt_d;
    logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;

    assign sc_last_o  = (sc_cnt_q == SC_LAST);
    assign sym_last_o = (sym_cnt_q == SYM_LAST);
    assign sc_cnt_o   = sc_cnt_q;
    assign sym_cnt_o  = sym_cnt_q;

    // Next-count logic: slot clear wins, subcarrier wraps at end of symbol.
    always_comb begin
        sc_cnt_d  = sc_cnt_q;
        sym_cnt_d = sym_cnt_q;
        if (slot_clr_i) begin
            sc_cnt_d  = '0;
            sym_cnt_d = '0;
        end else begin
            if (sc_inc_i) begin
                sc_cnt_d = sc_last_o ? '0 : sc_cnt_q + 1'b1;
            end
            if (sym_inc_i) begin
                sym_cnt_d = sym_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sc_cnt_q  <= '0;
            sym_cnt_q <= '0;
        end else begin
            sc_cnt_q  <= sc_cnt_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

endmodule

// File: rtl/re_write_ctrl.sv
// RE write controller: maps precoded samples of each OFDM symbol onto
// consecutive subcarrier addresses of the ping-pong memory, with a symbol
// end pulse, an idle gap between symbols and a slot end pulse.
// Optional build macro DMRS_INSERT_EN: symbol DMRS_SYM is sourced from the
// DMRS port instead of in_data.
module re_write_ctrl
    import re_write_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PRB  = 25,
    parameter int unsigned START_SC = 0,
    parameter int unsigned NUM_SYM  = 14,
    parameter int unsigned DMRS_SYM = 2,
    parameter int unsigned SYM_GAP  = 8,
    parameter int unsigned FFT_Len  = 18
) (
    input  logic            CLK,
    input  logic            RST,
    re_write_ctrl_if.slave  bus
);

    localparam int unsigned N_SC      = 12 * NUM_PRB;
    localparam logic [15:0] GAP_LAST  = 16'((SYM_GAP > 0) ? SYM_GAP - 1 : 0);

    if ((N_SC < 1) || (START_SC + N_SC > MAX_SC)) begin : g_bad_sc_cfg
        $error("re_write_ctrl: START_SC + 12*NUM_PRB must lie in 1..1625");
    end
    if ((NUM_SYM < 1) || (NUM_SYM > 15)) begin : g_bad_sym_cfg
        $error("re_write_ctrl: NUM_SYM must lie in 1..15");
    end

    re_state_e state_q, state_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;

    logic [ADDR_W-1:0] sc_cnt;
    logic [SYM_W-1:0]  sym_cnt;
    logic              sc_last, sym_last;
    logic              slot_clr, sym_inc;

    logic                      dmrs_sym;
    logic                      accept;
    logic signed [FFT_Len-1:0] sample;

    logic                      we_q;
    logic [ADDR_W-1:0]         addr_q;
    logic signed [FFT_Len-1:0] data_q;
    logic                      sym_done_q;
    logic                      re_done_q;

`ifdef DMRS_INSERT_EN
    assign dmrs_sym        = (sym_cnt == SYM_W'(DMRS_SYM));
    assign bus.in_ready    = (state_q == WRITE) && !dmrs_sym;
    assign bus.dmrs_ready  = (state_q == WRITE) && dmrs_sym;
    assign accept          = dmrs_sym ? (bus.dmrs_valid && bus.dmrs_ready)
                                      : (bus.in_valid && bus.in_ready);
    assign sample          = dmrs_sym ? bus.dmrs_data : bus.in_data;
`else
    localparam int unsigned DMRS_SYM_UNUSED = DMRS_SYM;
    logic dmrs_unused;
    assign dmrs_unused     = ^{bus.dmrs_data, bus.dmrs_valid};
    assign dmrs_sym        = 1'b0;
    assign bus.in_ready    = (state_q == WRITE);
    assign bus.dmrs_ready  = 1'b0;
    assign accept          = bus.in_valid && bus.in_ready;
    assign sample          = bus.in_data;
`endif

    re_sc_counter #(
        .N_SC    (N_SC),
        .NUM_SYM (NUM_SYM)
    ) u_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .slot_clr_i (slot_clr),
        .sc_inc_i   (accept),
        .sym_inc_i  (sym_inc),
        .sc_cnt_o   (sc_cnt),
        .sym_cnt_o  (sym_cnt),
        .sc_last_o  (sc_last),
        .sym_last_o (sym_last)
    );

    // Slot sequencing: write samples, close symbol, idle gap, close slot.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        slot_clr  = 1'b0;
        sym_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = WRITE;
                    slot_clr = 1'b1;
                end
            end
            WRITE: begin
                if (accept && sc_last) begin
                    state_d = SYM_END;
                end
            end
            SYM_END: begin
                sym_inc   = 1'b1;
                gap_cnt_d = '0;
                if (sym_last) begin
                    state_d = SLOT_END;
                end else if (SYM_GAP == 0) begin
                    state_d = WRITE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = WRITE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            SLOT_END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, gap counter and registered memory-side outputs. The write and
    // both done pulses are registered, which places Sym_Done one cycle after
    // the final write and RE_Done one cycle after the final Sym_Done.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            sym_done_q <= 1'b0;
            re_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            we_q       <= accept;
            if (accept) begin
                addr_q <= ADDR_W'(START_SC) + sc_cnt;
                data_q <= sample;
            end
            sym_done_q <= (state_q == SYM_END);
            re_done_q  <= (state_q == SLOT_END);
        end
    end

    assign bus.write_enable = we_q;
    assign bus.write_addr   = addr_q;
    assign bus.wr_data      = data_q;
    assign bus.Sym_Done     = sym_done_q;
    assign bus.RE_Done      = re_done_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.sym_idx      = sym_cnt;

endmodule
